arduino_spi_regs: RTL and testbench

Serial register front-end that takes SPI mode-0 write/read frames from the Arduino and drives the duty and max_value inputs of the downstream 8-bit PWM stage. Written values are held in shadow registers. They are committed to the live outputs either at the PWM period boundary, which avoids glitched periods, or immediately when the control register selects that. All SPI pins are asynchronous to clk and are synchronised inside the block.

---
 rtl/arduino_spi_regs.sv | 196 +++++++++++++++++++
 tb/tb_arduino_spi_regs.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arduino_spi_regs.sv
// SPI mode-0 register front-end for the 8-bit PWM stage: synchronised pin capture,
// 16-bit frame decode, shadow registers and period-aligned or immediate commit.
module arduino_spi_regs #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_MAX   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_n,
    output logic              miso,
    output logic              miso_oe,
    input  logic              period_done,
    output logic [DATA_W-1:0] duty,
    output logic [DATA_W-1:0] max_value,
    output logic              pwm_en,
    output logic              frame_done
);

    localparam int unsigned      FRAME_W     = 8 + DATA_W;
    localparam int unsigned      CNT_W       = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] HDR_LAST    = CNT_W'(7);
    localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] SHIFT_FIRST = CNT_W'(9);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DONE} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
    logic                   r_sclk_d, r_cs_d;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [FRAME_W-2:0]     r_shift;
    logic [DATA_W-1:0]      r_miso_sh;
    logic                   r_miso, r_miso_oe, r_frame_done;
    logic [DATA_W-1:0]      r_duty_sh, r_max_sh, r_duty, r_max;
    logic [1:0]             r_ctrl;
    logic                   r_pending, r_frame_err;

    logic                   w_sclk_s, w_mosi_s, w_cs_s;
    logic                   w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    logic [6:0]             w_hdr_addr, w_wr_addr;
    logic                   w_hdr_rw, w_frame_rw;
    logic [FRAME_W-1:0]     w_frame;
    logic [DATA_W-1:0]      w_wr_data, w_rd_data;
    logic                   w_last_rise, w_wr_en, w_rd_done, w_abort, w_commit;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;

    // Header fields are taken with the current bit still on the synchronised mosi.
    assign w_hdr_rw    = r_shift[6];
    assign w_hdr_addr  = {r_shift[5:0], w_mosi_s};
    assign w_frame     = {r_shift, w_mosi_s};
    assign w_frame_rw  = w_frame[FRAME_W-1];
    assign w_wr_addr   = w_frame[FRAME_W-2 -: 7];
    assign w_wr_data   = w_frame[DATA_W-1:0];

    assign w_last_rise = (r_state == ST_DATA) && w_sclk_rise && !w_cs_rise
                         && (r_bit_cnt == FRAME_LAST);
    assign w_wr_en     = w_last_rise & w_frame_rw;
    assign w_rd_done   = w_last_rise & ~w_frame_rw;
    assign w_abort     = w_cs_rise && ((r_state == ST_ADDR) || (r_state == ST_DATA));
    assign w_commit    = r_pending & (period_done | r_ctrl[1]);

    always_comb begin
        w_rd_data = '0;
        case (w_hdr_addr)
            7'h00:   w_rd_data = r_duty_sh;
            7'h01:   w_rd_data = r_max_sh;
            7'h02:   w_rd_data = {{(DATA_W-2){1'b0}}, r_ctrl};
            7'h03:   w_rd_data = {{(DATA_W-2){1'b0}}, r_frame_err, r_pending};
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_miso_sh    <= '0;
            r_miso       <= 1'b0;
            r_miso_oe    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_miso_oe    <= ~w_cs_s;
            if (w_cs_rise) begin
                r_state <= ST_IDLE;
                r_miso  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_cs_fall) begin
                        r_state   <= ST_ADDR;
                        r_bit_cnt <= '0;
                        r_miso_sh <= '0;
                        r_miso    <= 1'b0;
                    end
                    ST_ADDR: if (w_sclk_rise) begin
                        r_shift   <= {r_shift[FRAME_W-3:0], w_mosi_s};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == HDR_LAST) begin
                            r_state <= ST_DATA;
                            if (!w_hdr_rw) begin
                                r_miso    <= w_rd_data[DATA_W-1];
                                r_miso_sh <= {w_rd_data[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_sclk_rise) begin
                            r_shift   <= {r_shift[FRAME_W-3:0], w_mosi_s};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == FRAME_LAST) begin
                                r_state      <= ST_DONE;
                                r_frame_done <= 1'b1;
                                r_miso       <= 1'b0;
                            end
                        end else if (w_sclk_fall && r_bit_cnt >= SHIFT_FIRST) begin
                            // The fall right after the header leaves the MSB up for the 9th rise.
                            r_miso    <= r_miso_sh[DATA_W-1];
                            r_miso_sh <= {r_miso_sh[DATA_W-2:0], 1'b0};
                        end
                    end
                    ST_DONE: r_miso <= 1'b0;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_sh   <= '0;
            r_max_sh    <= RESET_MAX;
            r_duty      <= '0;
            r_max       <= RESET_MAX;
            r_ctrl      <= '0;
            r_pending   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_commit) begin
                r_duty <= r_duty_sh;
                r_max  <= r_max_sh;
            end
            if (w_wr_en) begin
                case (w_wr_addr)
                    7'h00:   r_duty_sh <= w_wr_data;
                    7'h01:   r_max_sh  <= w_wr_data;
                    7'h02:   r_ctrl    <= w_wr_data[1:0];
                    default: ;
                endcase
            end
            // A shadow write wins over a same-cycle commit so the new value is not lost.
            if (w_wr_en && (w_wr_addr == 7'h00 || w_wr_addr == 7'h01))
                r_pending <= 1'b1;
            else if (w_commit)
                r_pending <= 1'b0;
            if (w_abort)
                r_frame_err <= 1'b1;
            else if (w_rd_done && w_wr_addr == 7'h03)
                r_frame_err <= 1'b0;
        end
    end

    assign miso       = r_miso;
    assign miso_oe    = r_miso_oe;
    assign frame_done = r_frame_done;
    assign duty       = r_duty;
    assign max_value  = r_max;
    assign pwm_en     = r_ctrl[0];

endmodule

// File: tb/tb_arduino_spi_regs.sv
// Bench for arduino_spi_regs: directed vector table, hand-timed corner sequences,
// and randomised frames checked against a frame-level register model.
module tb_arduino_spi_regs;

    localparam int HALF = 8;

    logic       clk, rst_n, sclk, mosi, cs_n, period_done;
    logic       miso, miso_oe, pwm_en, frame_done;
    logic [7:0] duty, max_value;

    int n_vec = 0;
    int n_err = 0;
    int fd_cnt = 0;
    logic [7:0] fd_duty_at, fd_duty_next;
    logic       fd_prev = 1'b0;

    arduino_spi_regs #(.DATA_W(8), .SYNC_STAGES(2), .RESET_MAX(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .miso(miso), .miso_oe(miso_oe), .period_done(period_done),
        .duty(duty), .max_value(max_value), .pwm_en(pwm_en), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fd_prev) fd_duty_next = duty;
        if (frame_done) begin
            fd_cnt++;
            fd_duty_at = duty;
        end
        fd_prev = frame_done;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_frame(input logic [15:0] f, input int nbits, input bit pd_last,
                             output logic [7:0] rx);
        rx = 8'h00;
        cs_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            mosi = f[15-i];
            wait_clk(HALF);
            if (i >= 8) rx[15-i] = miso;
            sclk = 1'b1;
            if (pd_last && i == nbits - 1) begin
                wait_clk(2);
                period_done = 1'b1;
                wait_clk(1);
                period_done = 1'b0;
                wait_clk(HALF - 3);
            end else begin
                wait_clk(HALF);
            end
            sclk = 1'b0;
        end
        wait_clk(HALF);
        check("miso_oe_cs_low", miso_oe, 1);
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(8);
        check("miso_oe_cs_high", miso_oe, 0);
    endtask

    task automatic pulse_pd();
        period_done = 1'b1;
        wait_clk(1);
        period_done = 1'b0;
        wait_clk(3);
    endtask

    task automatic do_reset();
        cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; period_done = 1'b0;
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
    endtask

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        bit          pd;
        bit          rd;
        logic [7:0]  rx;
        logic [7:0]  duty;
        logic [7:0]  maxv;
        logic        en;
        int          fd;
    } vec_t;

    // Frame-level model state for the random phase
    logic [7:0] m_sh_duty, m_sh_max, m_duty, m_max;
    logic [1:0] m_ctrl;
    logic       m_pend, m_err;

    function automatic logic [7:0] m_read(input logic [6:0] a);
        case (a)
            7'h00:   return m_sh_duty;
            7'h01:   return m_sh_max;
            7'h02:   return {6'b0, m_ctrl};
            7'h03:   return {6'b0, m_err, m_pend};
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        vec_t        tbl[20];
        logic [7:0]  rx;
        logic [15:0] f;
        int          fd0, nb;
        logic [6:0]  a;
        logic [7:0]  d, exp_rx;
        bit          wr;

        tbl[0]  = '{16'h0200, 16, 0, 1, 8'h00, 8'h00, 8'hFF, 1'b0, 1};
        tbl[1]  = '{16'h8203, 16, 0, 0, 8'h00, 8'h00, 8'hFF, 1'b1, 1};
        tbl[2]  = '{16'h8080, 16, 0, 0, 8'h00, 8'h80, 8'hFF, 1'b1, 1};
        tbl[3]  = '{16'h0300, 16, 0, 1, 8'h00, 8'h80, 8'hFF, 1'b1, 1};
        tbl[4]  = '{16'h8201, 16, 0, 0, 8'h00, 8'h80, 8'hFF, 1'b1, 1};
        tbl[5]  = '{16'h813F, 16, 0, 0, 8'h00, 8'h80, 8'hFF, 1'b1, 1};
        tbl[6]  = '{16'h0300, 16, 1, 1, 8'h01, 8'h80, 8'h3F, 1'b1, 1};
        tbl[7]  = '{16'h0300, 16, 0, 1, 8'h00, 8'h80, 8'h3F, 1'b1, 1};
        tbl[8]  = '{16'h805A, 16, 0, 0, 8'h00, 8'h80, 8'h3F, 1'b1, 1};
        tbl[9]  = '{16'h0000, 16, 1, 1, 8'h5A, 8'h5A, 8'h3F, 1'b1, 1};
        tbl[10] = '{16'h8011, 11, 0, 0, 8'h00, 8'h5A, 8'h3F, 1'b1, 0};
        tbl[11] = '{16'h0300, 16, 0, 1, 8'h02, 8'h5A, 8'h3F, 1'b1, 1};
        tbl[12] = '{16'h0300, 16, 0, 1, 8'h00, 8'h5A, 8'h3F, 1'b1, 1};
        tbl[13] = '{16'h0100, 16, 0, 1, 8'h3F, 8'h5A, 8'h3F, 1'b1, 1};
        tbl[14] = '{16'h85AA, 16, 0, 0, 8'h00, 8'h5A, 8'h3F, 1'b1, 1};
        tbl[15] = '{16'h0500, 16, 0, 1, 8'h00, 8'h5A, 8'h3F, 1'b1, 1};
        tbl[16] = '{16'h83FF, 16, 0, 0, 8'h00, 8'h5A, 8'h3F, 1'b1, 1};
        tbl[17] = '{16'h0300, 16, 0, 1, 8'h00, 8'h5A, 8'h3F, 1'b1, 1};
        tbl[18] = '{16'h0200, 16, 0, 1, 8'h01, 8'h5A, 8'h3F, 1'b1, 1};
        tbl[19] = '{16'h7F00, 16, 0, 1, 8'h00, 8'h5A, 8'h3F, 1'b1, 1};

        rst_n = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; period_done = 1'b0;
        #2 rst_n = 1'b0;
        wait_clk(3);
        check("rst_duty", duty, 8'h00);
        check("rst_max", max_value, 8'hFF);
        check("rst_pwm_en", pwm_en, 0);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        wait_clk(4);

        for (int i = 0; i < 20; i++) begin
            fd0 = fd_cnt;
            spi_frame(tbl[i].frame, tbl[i].nbits, 1'b0, rx);
            if (tbl[i].pd) pulse_pd();
            if (tbl[i].rd) check($sformatf("tbl%0d_rx", i), rx, tbl[i].rx);
            check($sformatf("tbl%0d_duty", i), duty, tbl[i].duty);
            check($sformatf("tbl%0d_max", i), max_value, tbl[i].maxv);
            check($sformatf("tbl%0d_en", i), pwm_en, tbl[i].en);
            check($sformatf("tbl%0d_fd", i), fd_cnt - fd0, tbl[i].fd);
        end

        // Immediate mode: duty updates one clk after the frame_done pulse
        spi_frame(16'h8203, 16, 1'b0, rx);
        spi_frame(16'h8080, 16, 1'b0, rx);
        check("imm_duty_at_fd", fd_duty_at, 8'h5A);
        check("imm_duty_after_fd", fd_duty_next, 8'h80);
        spi_frame(16'h0300, 16, 1'b0, rx);
        check("imm_status", rx, 8'h00);

        // Write completing in the same cycle as period_done
        spi_frame(16'h8201, 16, 1'b0, rx);
        spi_frame(16'h8010, 16, 1'b0, rx);
        pulse_pd();
        check("same_pre_duty", duty, 8'h10);
        fd0 = fd_cnt;
        spi_frame(16'h8020, 16, 1'b1, rx);
        check("same_fd", fd_cnt - fd0, 1);
        check("same_duty_old", duty, 8'h10);
        spi_frame(16'h0300, 16, 1'b0, rx);
        check("same_pending", rx, 8'h01);
        pulse_pd();
        check("same_duty_new", duty, 8'h20);

        // Reset asserted after 9 bits of a write
        spi_frame(16'h8201, 16, 1'b0, rx);
        spi_frame(16'h8155, 16, 1'b0, rx);
        pulse_pd();
        check("prerst_max", max_value, 8'h55);
        cs_n = 1'b0;
        wait_clk(4);
        f = 16'h8077;
        for (int i = 0; i < 9; i++) begin
            mosi = f[15-i];
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(2);
        rst_n = 1'b0;
        #1;
        check("midrst_duty", duty, 8'h00);
        check("midrst_max", max_value, 8'hFF);
        check("midrst_en", pwm_en, 0);
        check("midrst_miso_oe", miso_oe, 0);
        check("midrst_fd", frame_done, 0);
        wait_clk(2);
        cs_n = 1'b1; mosi = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);
        spi_frame(16'h0300, 16, 1'b0, rx);
        check("postrst_status", rx, 8'h00);
        fd0 = fd_cnt;
        spi_frame(16'h8033, 16, 1'b0, rx);
        check("postrst_fd", fd_cnt - fd0, 1);
        check("postrst_duty_hold", duty, 8'h00);
        pulse_pd();
        check("postrst_duty", duty, 8'h33);

        // Randomised frames against the register model
        do_reset();
        m_sh_duty = 8'h00; m_sh_max = 8'hFF; m_duty = 8'h00; m_max = 8'hFF;
        m_ctrl = 2'b00; m_pend = 1'b0; m_err = 1'b0;
        for (int k = 0; k < 60; k++) begin
            int op;
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom_range(0, 5));
            d  = 8'($urandom);
            wr = (op >= 4 && op <= 8);
            nb = (op == 9) ? $urandom_range(1, 15) : 16;
            f  = {wr, a, d};
            exp_rx = m_read(a);
            fd0 = fd_cnt;
            spi_frame(f, nb, 1'b0, rx);
            if (op == 9) begin
                m_err = 1'b1;
            end else if (wr) begin
                if (a == 7'h00) begin m_sh_duty = d; m_pend = 1'b1; end
                if (a == 7'h01) begin m_sh_max = d; m_pend = 1'b1; end
                if (a == 7'h02) m_ctrl = d[1:0];
            end else begin
                check($sformatf("rnd%0d_rx_a%0h", k, a), rx, exp_rx);
                if (a == 7'h03) m_err = 1'b0;
            end
            if (m_pend && m_ctrl[1]) begin
                m_duty = m_sh_duty; m_max = m_sh_max; m_pend = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                pulse_pd();
                if (m_pend) begin
                    m_duty = m_sh_duty; m_max = m_sh_max; m_pend = 1'b0;
                end
            end
            check($sformatf("rnd%0d_fd", k), fd_cnt - fd0, (op == 9) ? 0 : 1);
            check($sformatf("rnd%0d_duty", k), duty, m_duty);
            check($sformatf("rnd%0d_max", k), max_value, m_max);
            check($sformatf("rnd%0d_en", k), pwm_en, m_ctrl[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
